// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of an 8-bit asynchronous SRAM.
// Each 16-bit word is moved as a low-byte phase followed by a high-byte phase.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [15:0]       wdata0,
  input  logic [15:0]       wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [15:0]       rdata,
  inout  wire  [7:0]        sram_data,
  output logic [ADDR_W:0]   sram_addr,
  output logic              sram_ce,
  output logic              sram_we,
  output logic              sram_oe
);
  localparam int              CNT_W    = $clog2(WAIT_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                phase_last;
  logic                owner_q, we_q, last1;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wdata_q;
  logic [7:0]          rd_lo, wbyte;
  logic                sel1, drive;

  assign phase_last = (cnt == CNT_LAST);
  // last1 records who was served last; requester 1 only wins a tie when it wasn't
  assign sel1       = req1 & (~req0 | ~last1);
  assign sram_data  = drive ? wbyte : 8'hzz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    sram_ce   = 1'b1;
    sram_we   = 1'b1;
    sram_oe   = 1'b1;
    sram_addr = '0;
    drive     = 1'b0;
    wbyte     = wdata_q[7:0];
    unique case (state)
      IDLE: begin
        // reset gates the grant so req held during reset never leaks a pulse
        if (reset && (req0 || req1)) begin
          gnt0      = ~sel1;
          gnt1      = sel1;
          state_nxt = LO;
        end
      end
      LO, HI: begin
        sram_ce   = 1'b0;
        sram_addr = {addr_q, state == HI};
        if (we_q) begin
          drive   = 1'b1;
          sram_we = phase_last;  // final cycle of the phase holds data with we released
          wbyte   = (state == HI) ? wdata_q[15:8] : wdata_q[7:0];
        end else begin
          sram_oe = 1'b0;
        end
        if (phase_last) state_nxt = (state == LO) ? HI : DONE;
      end
      DONE: begin
        done0     = ~owner_q;
        done1     = owner_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      last1   <= 1'b1;
      rd_lo   <= '0;
      rdata   <= '0;
    end else begin
      cnt <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      if (gnt0 || gnt1) begin
        owner_q <= gnt1;
        last1   <= gnt1;
        we_q    <= gnt1 ? we1    : we0;
        addr_q  <= gnt1 ? addr1  : addr0;
        wdata_q <= gnt1 ? wdata1 : wdata0;
      end
      // rdata only changes on entry to DONE so it holds outside the done pulse
      if (state == LO && !we_q && phase_last) rd_lo <= sram_data;
      if (state == HI && !we_q && phase_last) rdata <= {sram_data, rd_lo};
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM byte model, word-level reference memory,
// bus-rule monitor and randomized two-requester traffic.
module tb_sram_arbiter;
  localparam int AW = 20;
  localparam int PH = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic            req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0]   addr0 = '0, addr1 = '0;
  logic [15:0]     wdata0 = '0, wdata1 = '0;
  logic            gnt0, gnt1, done0, done1, sram_ce, sram_we, sram_oe;
  logic [15:0]     rdata;
  logic [AW:0]     sram_addr;
  wire  [7:0]      sram_data;
  logic [7:0]      mem_rd = '0;

  assign sram_data = (!sram_ce && !sram_oe) ? mem_rd : 8'hzz;

  sram_arbiter #(.WAIT_CYCLES(2), .ADDR_W(AW)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .sram_data(sram_data), .sram_addr(sram_addr),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_oe(sram_oe)
  );

  logic          z_req1 = 0;
  logic          z_gnt0, z_gnt1, z_done0, z_done1, z_ce, z_we, z_oe;
  logic [15:0]   z_rdata;
  logic [AW:0]   z_sa;
  wire  [7:0]    z_data;

  sram_arbiter #(.WAIT_CYCLES(0), .ADDR_W(AW)) u_dut_w0 (
    .clk(clk), .reset(reset),
    .req0(1'b0), .req1(z_req1), .we0(1'b0), .we1(1'b1),
    .addr0(20'h0), .addr1(20'h00010), .wdata0(16'h0), .wdata1(16'h1234),
    .gnt0(z_gnt0), .gnt1(z_gnt1), .done0(z_done0), .done1(z_done1),
    .rdata(z_rdata), .sram_data(z_data), .sram_addr(z_sa),
    .sram_ce(z_ce), .sram_we(z_we), .sram_oe(z_oe)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SRAM contents: bytes never written read back a fixed address-derived pattern
  logic [7:0]  mem [int];
  logic [15:0] ref_w [int];
  function automatic logic [7:0] init_byte(int a);
    return 8'((a * 37 + 11) ^ (a >> 7));
  endfunction
  function automatic logic [7:0] sram_byte(int a);
    return mem.exists(a) ? mem[a] : init_byte(a);
  endfunction
  function automatic logic [15:0] ref_word(int a);
    return ref_w.exists(a) ? ref_w[a] : {init_byte(2 * a + 1), init_byte(2 * a)};
  endfunction

  int            cyc = 0, k = 0, n_done = 0;
  bit            rr_last1 = 1;
  logic [15:0]   held = '0;
  bit            cur_we;
  logic [AW-1:0] cur_addr;
  logic [15:0]   cur_d;
  int            gseq[$], gcyc[$], dcyc[$];

  always @(negedge clk) begin
    #2;
    cyc++;
    if (!reset) begin
      rr_last1 = 1;
      held     = '0;
      k        = 0;
    end else begin
      if (gnt0 || gnt1) begin
        chk("gnt_excl", 32'(gnt0 & gnt1), 0);
        chk("gnt_req", 32'(gnt1 ? req1 : req0), 1);
        if (req0 && req1) chk("rr_tie", 32'(gnt1), 32'(!rr_last1));
        rr_last1 = gnt1;
        cur_we   = gnt1 ? we1 : we0;
        cur_addr = gnt1 ? addr1 : addr0;
        cur_d    = gnt1 ? wdata1 : wdata0;
        k        = 0;
        gseq.push_back(gnt1 ? 1 : 0);
        gcyc.push_back(cyc);
      end
      if (done0 || done1) begin
        chk("done_excl", 32'((done0 & done1) | (gnt0 | gnt1)), 0);
        chk("bus_len", k, 2 * PH);
        held = rdata;
        dcyc.push_back(cyc);
        n_done++;
      end else begin
        chk("rd_hold", 32'(rdata), 32'(held));
      end
      if (!sram_ce) begin
        chk("bus_addr", 32'(sram_addr), 32'({cur_addr, k >= PH}));
        if (cur_we) begin
          chk("bus_wr_strb", 32'({sram_we, sram_oe}), 32'({(k % PH) == PH - 1, 1'b1}));
          chk("bus_wbyte", 32'(sram_data), 32'(k >= PH ? cur_d[15:8] : cur_d[7:0]));
        end else begin
          chk("bus_rd_strb", 32'({sram_we, sram_oe}), 32'b10);
        end
        k++;
      end else begin
        chk("bus_idle", 32'({sram_we, sram_oe, sram_addr}), 32'({2'b11, 21'd0}));
      end
    end
    if (!sram_ce && !sram_we) mem[int'(sram_addr)] = sram_data;
    mem_rd = sram_byte(int'(sram_addr));
  end

  task automatic issue(input int who, input bit w, input logic [AW-1:0] a, input logic [15:0] d);
    bit g;
    int lat;
    @(negedge clk);
    if (who == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    else          begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    g = 0;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (who == 0 ? gnt0 : gnt1) begin g = 1; break; end
      @(negedge clk);
    end
    chk("gnt_seen", 32'(g), 1);
    @(negedge clk);
    // scramble: inputs must have been latched at grant
    if (who == 0) begin req0 = 0; we0 = ~w; addr0 = ~a; wdata0 = ~d; end
    else          begin req1 = 0; we1 = ~w; addr1 = ~a; wdata1 = ~d; end
    if (!g) return;
    lat = 0;
    for (int n = 1; n < 100; n++) begin
      #1;
      if (who == 0 ? done0 : done1) begin lat = n; break; end
      @(negedge clk);
    end
    chk("latency", lat, 2 * PH + 1);
    if (lat != 0) begin
      if (w) ref_w[int'(a)] = d;
      else   chk("rdata", 32'(rdata), 32'(ref_word(int'(a))));
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom_range(0, 3) == 0) ? 20'hFFFFF : 20'($urandom_range(0, 15));
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, lat, wl, cl;
    logic [15:0] zw;

    // reset holds grants low even with both requests up
    req0 = 1; req1 = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", 32'({gnt0, gnt1, done0, done1}), 0);
    chk("rst_strb", 32'({sram_ce, sram_we, sram_oe}), 32'b111);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_rdata", 32'(rdata), 0);
    req0 = 0; req1 = 0;
    @(negedge clk) reset = 1;

    // simultaneous requests right after reset: 0, 1, 0
    gseq.delete(); gcyc.delete(); dcyc.delete();
    fork
      begin issue(0, 1, 20'h5, 16'hAAAA); issue(0, 0, 20'h5, 16'h0); end
      issue(1, 0, 20'h5, 16'h0);
    join
    chk("tie_cnt", gseq.size(), 3);
    if (gseq.size() == 3 && dcyc.size() >= 2) begin
      chk("tie_order", 32'({gseq[0][1:0], gseq[1][1:0], gseq[2][1:0]}), 32'b00_01_00);
      chk("tie_gap0", gcyc[1] - dcyc[0], 1);
      chk("tie_gap1", gcyc[2] - dcyc[1], 1);
    end

    issue(1, 1, 20'h00010, 16'h1234);
    chk("wr_lo_byte", 32'(sram_byte(32'h20)), 32'h34);
    chk("wr_hi_byte", 32'(sram_byte(32'h21)), 32'h12);
    issue(0, 0, 20'h00010, 16'h0);
    chk("rd_1234", 32'(rdata), 32'h1234);
    issue(0, 1, 20'hFFFFF, 16'h8001);
    chk("top_lo_byte", 32'(sram_byte(32'h1FFFFE)), 32'h01);
    chk("top_hi_byte", 32'(sram_byte(32'h1FFFFF)), 32'h80);
    issue(1, 0, 20'hFFFFF, 16'h0);
    chk("rd_8001", 32'(rdata), 32'h8001);

    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        issue(0, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
      end
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        issue(1, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
      end
    join

    // reset during the high-byte phase of a write from requester 0
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 20'h77777; wdata0 = 16'hBEEF;
    #1 chk("mw_gnt", 32'(gnt0), 1);
    @(negedge clk) req0 = 0;
    repeat (4) @(negedge clk);
    #3;
    chk("mw_in_hi", 32'({sram_ce, sram_addr[0]}), 32'b01);
    d0 = n_done;
    reset = 0;
    #1;
    chk("mw_strb", 32'({sram_ce, sram_we, sram_oe}), 32'b111);
    chk("mw_addr", 32'(sram_addr), 0);
    chk("mw_outs", 32'({gnt0, gnt1, done0, done1}), 0);
    chk("mw_rdata", 32'(rdata), 0);
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (10) @(negedge clk);
    chk("mw_no_done", n_done, d0);
    gseq.delete();
    fork
      issue(0, 0, 20'h3, 16'h0);
      issue(1, 0, 20'h3, 16'h0);
    join
    chk("mw_tie_first", gseq.size() > 0 ? gseq[0] : -1, 0);

    // single-cycle phases
    @(negedge clk) z_req1 = 1;
    #1 chk("w0_gnt", 32'(z_gnt1), 1);
    lat = 0; wl = 0; cl = 0; zw = '0;
    for (int n = 1; n < 20; n++) begin
      @(negedge clk);
      z_req1 = 0;
      #1;
      if (!z_ce) begin
        cl++;
        if (!z_we) wl++;
        chk("w0_addr", 32'(z_sa[AW:1]), 32'h10);
        if (z_sa[0]) zw[15:8] = z_data;
        else         zw[7:0]  = z_data;
      end
      if (z_done1) begin lat = n; break; end
    end
    chk("w0_latency", lat, 3);
    chk("w0_we_low", wl, 0);
    chk("w0_ce_low", cl, 2);
    chk("w0_bytes", 32'(zw), 32'h1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: extra clk cycles each byte phase is held on the SRAM; a phase lasts WAIT_CYCLES+1 cycles (3 x 20 ns at 50 MHz).
REQ-002 Parameter ADDR_W, default 20: word-address width; the SRAM byte address is ADDR_W+1 bits.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req0, req1  in  1 each  access request; requester 0 = GDP parameter fetch, requester 1 = UART parameter loader.
REQ-006 we0, we1  in  1 each  1 = write word, 0 = read word; sampled at grant.
REQ-007 addr0, addr1  in  ADDR_W each  word address; sampled at grant.
REQ-008 wdata0, wdata1  in  16 each  signed write word (num format); sampled at grant.
REQ-009 gnt0, gnt1  out  1 each  one-cycle grant pulse; request inputs latched on this cycle.
REQ-010 done0, done1  out  1 each  one-cycle completion pulse to the granted requester.
REQ-011 rdata  out  16  read word; valid only while done0 or done1 is high after a read.
REQ-012 sram_data  inout  8  SRAM data bus.
REQ-013 sram_addr  out  ADDR_W+1  SRAM byte address.
REQ-014 sram_ce, sram_we, sram_oe  out  1 each  active-low SRAM strobes.

Function
REQ-015 The FSM SHALL have states IDLE, LO, HI, DONE.
REQ-016 IDLE: the SRAM bus is idle: strobes high, sram_data high-Z, sram_addr 0.
REQ-017 IDLE with any req high: assert the selected gnt for exactly one cycle, latch we/addr/wdata, next state LO.
REQ-018 Arbitration SHALL be round-robin: a single requester is granted directly; when both request, grant the one not served last; after reset requester 0 wins the first tie.
REQ-019 Each requester holds req until it sees gnt; req high in the same cycle as gnt or done is ignored; a new request is considered only from IDLE.
REQ-020 LO: sram_addr={addr,1'b0}; HI: sram_addr={addr,1'b1}; each phase lasts exactly WAIT_CYCLES+1 cycles, counted by an internal phase counter that clears on every state change.
REQ-021 During LO and HI, sram_ce is held low.
REQ-022 Read phase: sram_oe low for the whole phase; sram_we high; the byte is captured on the final cycle of the phase; LO gives rdata[7:0], HI gives rdata[15:8].
REQ-023 Write phase: sram_data driven for the whole phase with wdata[7:0] (LO) or wdata[15:8] (HI); sram_we low for the first WAIT_CYCLES cycles and high on the final cycle (data hold); sram_oe high.
REQ-024 sram_data SHALL be driven only in write phases; it is never driven while sram_oe is low.
REQ-025 DONE lasts one cycle: pulse done of the granted requester, present rdata for a read, return to IDLE.
REQ-026 Latency from gnt cycle to done cycle SHALL be 2*(WAIT_CYCLES+1)+1 cycles (7 at default); back-to-back transactions have one IDLE cycle between done and the next gnt.
REQ-027 rdata SHALL hold its last value outside DONE; gnt0/gnt1 and done0/done1 are never high together.

Reset
REQ-028 reset low SHALL, asynchronously and at any point including mid-transaction: force state to IDLE; set sram_ce=sram_we=sram_oe=1, sram_data high-Z, sram_addr=0, gnt*=0, done*=0, rdata=0; set the round-robin pointer so requester 0 wins the next tie.
REQ-029 A transaction interrupted by reset is abandoned with no done pulse; the requester re-issues it.

Verification
REQ-030 Single write: req1, we1=1, addr1=0x00010, wdata1=0x1234 -> gnt1 once; byte 0x34 at 0x00020, then 0x12 at 0x00021; sram_we low 2 of 3 cycles per phase; done1 exactly 7 cycles after gnt1.
REQ-031 Read-back: req0, we0=0, addr0=0x00010 with an SRAM model holding that data -> sram_oe low, sram_data undriven by the DUT; done0 with rdata=0x1234 exactly 7 cycles after gnt0.
REQ-032 Tie: req0 and req1 rise together after reset and stay up -> grants in order gnt0, gnt1, gnt0; each done precedes the next grant by one cycle.
REQ-033 Reset mid-write: reset low during the HI phase -> strobes go high, sram_data goes high-Z without waiting for clk; no done pulse; the next tie is granted to requester 0.
REQ-034 Negative value and top address: write 0x8001 to addr 0xFFFFF, then read it back -> sram_addr 0x1FFFFE then 0x1FFFFF; rdata=0x8001 (-32767).
REQ-035 WAIT_CYCLES=0 build: single write -> one-cycle phases with sram_we high during the hold cycle; done exactly 3 cycles after gnt.
